// File: rtl/acc_alu_if.sv
// Handshake and accumulator-side bundle for acc_alu_seq.
// master: requester/accumulator side; slave: the sequencer.
interface acc_alu_if;
  logic       start;
  logic [3:0] op;
  logic [7:0] dr;
  logic [7:0] ac;
  logic       busy;
  logic       done;
  logic [7:0] ac_data;
  logic       ac_ld;
  logic       ac_inc;
  logic       ac_clr;
  logic       e;
  logic       z;

  modport master (
    output start, op, dr, ac,
    input  busy, done, ac_data,
    input  ac_ld, ac_inc, ac_clr, e, z
  );

  modport slave (
    input  start, op, dr, ac,
    output busy, done, ac_data,
    output ac_ld, ac_inc, ac_clr, e, z
  );
endinterface

// File: rtl/acc_alu_seq.sv
// Sequenced ALU feeding the 8-bit accumulator (Data/LD/INC/CLR), owning E and Z.
// Ports: clk, rst_n (async low), bus (acc_alu_if.slave). Option: ACC_ALU_MUL_EN.
module acc_alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  acc_alu_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
`ifdef ACC_ALU_MUL_EN
  localparam logic [1:0] S_MUL   = 2'd2;
`endif
  localparam logic [1:0] S_WRITE = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [7:0] dr_q, dr_d;
  logic [7:0] ac_q, ac_d;
  logic [7:0] data_q, data_d;
  logic       ld_q, ld_d;
  logic       inc_q, inc_d;
  logic       clr_q, clr_d;
  logic       done_q, done_d;
  logic       e_q, e_d;
  logic       en_q, en_d;
  logic       z_q, z_d;

`ifdef ACC_ALU_MUL_EN
  logic [15:0] prod_q, prod_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [8:0]  psum;
`endif

  // EXEC-stage decode of the latched operation
  logic [8:0] sum;
  logic [7:0] res;
  logic       x_ld, x_inc, x_clr, x_e, x_z, x_mul;

  always_comb begin
    sum   = {1'b0, ac_q} + {1'b0, dr_q};
    res   = data_q;
    x_ld  = 1'b0;
    x_inc = 1'b0;
    x_clr = 1'b0;
    x_e   = e_q;
    x_z   = z_q;
    x_mul = 1'b0;
    case (op_q)
      4'd1: begin res = ac_q & dr_q; x_ld = 1'b1; end
      4'd2: begin
        res  = sum[7:0];
        x_e  = sum[8];
        x_ld = 1'b1;
      end
      4'd3: begin res = dr_q; x_ld = 1'b1; end
      4'd4: begin x_clr = 1'b1; x_z = 1'b1; end
      4'd5: begin res = ~ac_q; x_ld = 1'b1; end
      4'd6: x_e = ~e_q;
      4'd7: x_e = 1'b0;
      4'd8: begin
        res  = {e_q, ac_q[7:1]};
        x_e  = ac_q[0];
        x_ld = 1'b1;
      end
      4'd9: begin
        res  = {ac_q[6:0], e_q};
        x_e  = ac_q[7];
        x_ld = 1'b1;
      end
      4'd10: begin
        x_inc = 1'b1;
        x_z   = (ac_q == 8'hFF);
      end
`ifdef ACC_ALU_MUL_EN
      4'd11: x_mul = 1'b1;
`endif
      default: ;
    endcase
    if (x_ld) x_z = (res == 8'h00);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dr_d    = dr_q;
    ac_d    = ac_q;
    data_d  = data_q;
    ld_d    = 1'b0;
    inc_d   = 1'b0;
    clr_d   = 1'b0;
    done_d  = 1'b0;
    e_d     = e_q;
    en_d    = en_q;
    z_d     = z_q;
`ifdef ACC_ALU_MUL_EN
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    // one multiplier bit per cycle: add into high half, shift right
    psum    = {1'b0, prod_q[15:8]} +
              (prod_q[0] ? {1'b0, dr_q} : 9'd0);
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_EXEC;
          op_d    = bus.op;
          dr_d    = bus.dr;
          ac_d    = bus.ac;
        end
      end
      S_EXEC: begin
`ifdef ACC_ALU_MUL_EN
        if (x_mul) begin
          state_d = S_MUL;
          prod_d  = {8'h00, ac_q};
          cnt_d   = 3'd0;
        end else begin
`endif
          state_d = S_WRITE;
          done_d  = 1'b1;
          ld_d    = x_ld;
          inc_d   = x_inc;
          clr_d   = x_clr;
          z_d     = x_z;
          en_d    = x_e;
          if (x_ld) data_d = res;
`ifdef ACC_ALU_MUL_EN
        end
`endif
      end
`ifdef ACC_ALU_MUL_EN
      S_MUL: begin
        prod_d = {psum, prod_q[7:1]};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_WRITE;
          done_d  = 1'b1;
          ld_d    = 1'b1;
          data_d  = prod_d[7:0];
          z_d     = (prod_d[7:0] == 8'h00);
          en_d    = |prod_d[15:8];
        end
      end
`endif
      S_WRITE: begin
        // E commits with the accumulator capture edge
        state_d = S_IDLE;
        e_d     = en_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      dr_q    <= 8'h00;
      ac_q    <= 8'h00;
      data_q  <= 8'h00;
      ld_q    <= 1'b0;
      inc_q   <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      e_q     <= 1'b0;
      en_q    <= 1'b0;
      z_q     <= 1'b0;
`ifdef ACC_ALU_MUL_EN
      prod_q  <= 16'h0000;
      cnt_q   <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dr_q    <= dr_d;
      ac_q    <= ac_d;
      data_q  <= data_d;
      ld_q    <= ld_d;
      inc_q   <= inc_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      e_q     <= e_d;
      en_q    <= en_d;
      z_q     <= z_d;
`ifdef ACC_ALU_MUL_EN
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.ac_data = data_q;
  assign bus.ac_ld   = ld_q;
  assign bus.ac_inc  = inc_q;
  assign bus.ac_clr  = clr_q;
  assign bus.e       = e_q;
  assign bus.z       = z_q;

endmodule

// File: tb/tb_acc_alu_seq.sv
// Scoreboard bench for acc_alu_seq with an arithmetic reference model.
// The bench plays the accumulator register and feeds AC back.
module tb_acc_alu_seq;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;
  bit   mon_en;

  acc_alu_if bus ();

  acc_alu_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       ld;
    logic       inc;
    logic       clr;
    logic       e;
    logic       z;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  int m_acc;
  int m_data;
  int m_e;
  int m_z;

  bit         pend_e;
  logic       pend_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d",
               nm, act, req, cyc);
    end
  endtask

  // Reference model: applies the opcode rules to the bench's
  // accumulator/E/Z state and returns the expected WRITE-cycle view.
  function automatic exp_t model(input int op, input int d,
                                 input int accept_cyc);
    exp_t x;
    int   a;
    int   r;
    int   s;
    int   lat;
    bit   ld;
    a   = m_acc;
    r   = m_data;
    ld  = 0;
    lat = 1;
    x.ld  = 1'b0;
    x.inc = 1'b0;
    x.clr = 1'b0;
    case (op)
      1:  begin r = a & d; ld = 1; end
      2:  begin
        s = a + d;
        r = s % 256;
        m_e = (s > 255) ? 1 : 0;
        ld = 1;
      end
      3:  begin r = d; ld = 1; end
      4:  begin x.clr = 1'b1; m_z = 1; m_acc = 0; end
      5:  begin r = 255 - a; ld = 1; end
      6:  m_e = 1 - m_e;
      7:  m_e = 0;
      8:  begin
        r = m_e * 128 + a / 2;
        m_e = a % 2;
        ld = 1;
      end
      9:  begin
        r = (a * 2) % 256 + m_e;
        m_e = a / 128;
        ld = 1;
      end
      10: begin
        x.inc = 1'b1;
        m_acc = (a + 1) % 256;
        m_z = (m_acc == 0) ? 1 : 0;
      end
`ifdef ACC_ALU_MUL_EN
      11: begin
        s = a * d;
        r = s % 256;
        m_e = (s > 255) ? 1 : 0;
        ld = 1;
        lat = 9;
      end
`endif
      default: ;
    endcase
    if (ld) begin
      x.ld   = 1'b1;
      m_data = r;
      m_acc  = r;
      m_z    = (r == 0) ? 1 : 0;
    end
    x.data = m_data[7:0];
    x.e    = m_e[0];
    x.z    = m_z[0];
    x.cyc  = accept_cyc + lat;
    return x;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic issue(input int op, input int d);
    int w;
    w = 0;
    while (bus.busy && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (bus.busy) begin
      chk("issue_busy_timeout", 16'(bus.busy), 16'd0);
      return;
    end
    bus.start = 1'b1;
    bus.op    = 4'(op);
    bus.dr    = 8'(d);
    bus.ac    = 8'(m_acc);
    sb.push_back(model(op, d, cyc + 1));
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 4'($urandom_range(0, 15));
    bus.dr    = 8'($urandom_range(0, 255));
    bus.ac    = 8'($urandom_range(0, 255));
  endtask

  // Monitor: compares whenever the DUT pulses DONE; E one cycle later.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pend_e) begin
        chk("e_after_write", 16'(bus.e), 16'(pend_ev));
        pend_e = 1'b0;
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 16'(bus.done), 16'd0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("done_cycle", 16'(cyc), 16'(x.cyc));
          chk("ac_data", 16'(bus.ac_data), 16'(x.data));
          chk("strobes", {13'd0, bus.ac_ld, bus.ac_inc, bus.ac_clr},
              {13'd0, x.ld, x.inc, x.clr});
          chk("z", 16'(bus.z), 16'(x.z));
          pend_e  = 1'b1;
          pend_ev = x.e;
        end
      end else begin
        chk("idle_strobes", {13'd0, bus.ac_ld, bus.ac_inc, bus.ac_clr},
            16'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    errors = 0; checks = 0; cyc = 0;
    mon_en = 1'b0; pend_e = 1'b0; pend_ev = 1'b0;
    m_acc = 0; m_data = 0; m_e = 0; m_z = 0;
    bus.start = 1'b0; bus.op = 4'd0; bus.dr = 8'h00; bus.ac = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_outs", {bus.done, bus.ac_ld, bus.ac_inc, bus.ac_clr,
                     bus.e, bus.z, bus.ac_data}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of an ADD WRITE cycle
    bus.start = 1'b1; bus.op = 4'd2; bus.ac = 8'hFF; bus.dr = 8'h12;
    @(negedge clk);
    bus.start = 1'b0;
    w = 0;
    while (!bus.done && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("pre_rst_ld", 16'(bus.ac_ld), 16'd1);
    chk("pre_rst_data", 16'(bus.ac_data), 16'h11);
    rst_n = 1'b0;
    #1;
    chk("rst_ld_drop", 16'(bus.ac_ld), 16'd0);
    chk("rst_mid_outs", {bus.busy, bus.done, bus.ac_inc, bus.ac_clr,
                         bus.e, bus.z, bus.ac_data}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 16'(bus.busy), 16'd0);
    chk("post_rst_e", 16'(bus.e), 16'd0);

    mon_en = 1'b1;

    // Directed: carry, circulate, strobe selection, MUL
    issue(3, 8'hFF);
    issue(2, 8'h01);
    issue(3, 8'h80);
    issue(8, 0);
    issue(9, 0);
    issue(4, 0);
    issue(3, 8'hFF);
    issue(10, 0);
    issue(6, 0);
    issue(7, 0);
    issue(15, 8'h33);
    issue(3, 8'h12);
    issue(11, 8'h10);
    issue(5, 0);

    // Randomized operations
    for (int i = 0; i < 300; i++)
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));

    // START held for six edges: accepted at edges n and n+3 only
    w = 0;
    while (bus.busy && w < 40) begin
      @(negedge clk);
      w++;
    end
    bus.start = 1'b1; bus.op = 4'd3; bus.dr = 8'h5A;
    bus.ac = 8'(m_acc);
    sb.push_back(model(3, 8'h5A, cyc + 1));
    sb.push_back(model(3, 8'h5A, cyc + 4));
    repeat (6) @(negedge clk);
    bus.start = 1'b0;

    issue(2, 8'h01);

    w = 0;
    while ((sb.size() != 0 || bus.busy) && w < 60) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    chk("sb_drained", 16'(sb.size()), 16'd0);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_alu_seq.md
# acc_alu_seq

- Sequenced ALU directly upstream of the 8-bit accumulator register; it is the only driver of that register's Data, LD, INC and CLR inputs.
- Accepts one register-reference or memory-operand operation per START handshake and computes the result from the current accumulator value (AC) and the memory operand (DR).
- Owns the E (extend/carry) flip-flop and a registered zero flag.
- Issues exactly one accumulator strobe per operation, or none.

## Interface
Parameters: none; data width fixed at 8.
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  operation request; sampled only while BUSY=0
- OP  in  4  opcode, captured with START
- DR  in  8  memory operand, captured with START
- AC  in  8  accumulator Q, captured with START
- BUSY  out  1  high from the cycle after START acceptance through the WRITE cycle
- DONE  out  1  one-cycle pulse during WRITE
- AC_DATA  out  8  result to accumulator Data
- AC_LD  out  1  accumulator load strobe
- AC_INC  out  1  accumulator increment strobe
- AC_CLR  out  1  accumulator clear strobe
- E  out  1  extend flip-flop
- Z  out  1  registered zero flag of the value the accumulator will hold

## Operation
- FSM states: IDLE, EXEC, MUL (optional), WRITE.
  - IDLE → EXEC: on START=1. OP, DR and AC are latched.
  - EXEC → WRITE: always, except OP=MUL when MUL is compiled in.
  - WRITE → IDLE: always.
- Opcodes and what each does in WRITE:
  - 0 NOP: no strobe.
  - 1 AND: result = AC & DR; AC_LD.
  - 2 ADD: {E, result} = AC + DR (9-bit sum); AC_LD.
  - 3 LDA: result = DR; AC_LD.
  - 4 CLA: AC_CLR; Z=1.
  - 5 CMA: result = ~AC; AC_LD.
  - 6 CME: E = ~E; no strobe.
  - 7 CLE: E = 0; no strobe.
  - 8 CIR: result = {E, AC[7:1]}, E = AC[0]; AC_LD.
  - 9 CIL: result = {AC[6:0], E}, E = AC[7]; AC_LD.
  - 10 INC: AC_INC only; E unchanged; Z = ((AC+1) mod 256 == 0).
  - 11 MUL: see Configuration.
  - 12–15 illegal: handled as NOP, DONE still pulses.
- Strobes:
  - AC_LD, AC_INC and AC_CLR are mutually exclusive and high only in WRITE.
  - AC_DATA is the registered result; it holds its value between operations.
- Flag updates:
  - E is updated on the edge that ends WRITE, i.e. the same edge on which the accumulator captures.
  - ADD carry-out of 255+1 gives E=1 and result 0x00.
  - Z updates only for opcodes that strobe the accumulator; all other opcodes hold Z.
- START while BUSY=1 is ignored (not queued).
- Reset (asynchronous, any state):
  - state=IDLE.
  - BUSY, DONE, AC_LD, AC_INC, AC_CLR = 0.
  - AC_DATA = 0x00, E = 0, Z = 0.
  - An operation in flight is abandoned and no strobe is emitted.

## Timing
- START sampled at edge n. EXEC during cycle n+1. WRITE during cycle n+2. The accumulator captures at edge n+2.
- Back-to-back throughput is one operation per 3 cycles. A START held high during WRITE is not accepted; the next acceptance is the first edge with the FSM in IDLE.
- All outputs are registered or decoded from state registers. There are no combinational paths from inputs to outputs.
- AC is sampled at START only. The accumulator must not be modified by any other source while BUSY=1.

## Configuration
- Macro: ACC_ALU_MUL_EN.
- Defined:
  - OP=11 performs an 8×8 unsigned shift-add multiply of AC and DR.
  - EXEC → MUL, 8 iterations, one multiplier bit per cycle, then WRITE.
  - result = low byte of the product, with AC_LD.
  - E = 1 if the high byte is nonzero, else 0.
  - The accumulator captures at edge n+10; BUSY stays high throughout.
  - Reset during MUL behaves as any other reset.
- Undefined:
  - MUL state and datapath are absent.
  - OP=11 behaves as an illegal opcode: NOP timing, DONE pulse, no strobe, E and Z unchanged.

## Test plan
- Reset values: RST_N=0 mid-WRITE of ADD → AC_LD drops immediately; all outputs zero; after release, IDLE with BUSY=0.
- ADD with carry: AC=0xFF, DR=0x01, OP=2 → AC_LD high in cycle n+2, AC_DATA=0x00, E=1, Z=1, DONE one pulse.
- Circulate through E: E=1, AC=0x80, OP=8 → AC_DATA=0xC0, E=0. Then AC=0xC0, OP=9 → AC_DATA=0x80, E=1.
- Strobe selection: OP=4 → only AC_CLR. OP=10 with AC=0xFF → only AC_INC, Z=1, E unchanged. OP=6 → no strobe, E toggles, DONE pulses.
- Handshake: START held high for 6 cycles with OP=3, DR=0x5A → exactly two operations accepted (edges n and n+3); extra STARTs during BUSY ignored; AC_DATA=0x5A.
- MUL, with ACC_ALU_MUL_EN: AC=0x12, DR=0x10 → AC_LD at cycle n+10, AC_DATA=0x20, E=1. Without the macro, the same stimulus → DONE at n+2, no strobe.
